// File: rtl/pb_range_checker_md_pkg.sv
// Shared Global Controller definitions: bound width default, config field
// encodings, commit FSM states and a ceil-log2 helper.
package gc_pkg;

  localparam int unsigned IVAR_W_DEF = 16;

  typedef enum logic [1:0] {
    CFG_MIN = 2'b00,
    CFG_MAX = 2'b01,
    CFG_IGN = 2'b10,
    CFG_RSV = 2'b11
  } cfg_field_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_st_e;

  // Ceil-log2, floored at 1 so that a single PB or single dim still gets an
  // address bit instead of a zero-width field.
  function automatic int unsigned CLOG2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pb_range_checker_md_if.sv
// Sample, configuration and hit signals between the GC iteration counters,
// the config master and the program-block range checker.
interface pb_range_checker_md_if
  import gc_pkg::*;
#(
  parameter int unsigned IVAR_W  = IVAR_W_DEF,
  parameter int unsigned NUM_DIM = 3,
  parameter int unsigned NUM_PB  = 8
) ();

  localparam int unsigned ADDR_W = CLOG2(NUM_PB) + CLOG2(NUM_DIM) + 2;

  logic [NUM_DIM*IVAR_W-1:0] ivar;
  logic                      ivar_valid;
  logic                      ivar_last;
  logic                      cfg_wr;
  logic [ADDR_W-1:0]         cfg_addr;
  logic [IVAR_W-1:0]         cfg_data;
  logic                      cfg_ready;
  logic                      commit_req;
  logic                      commit_done;
  logic [NUM_PB-1:0]         hit;
  logic                      hit_valid;

  modport master (
    output ivar, ivar_valid, ivar_last, cfg_wr, cfg_addr, cfg_data, commit_req,
    input  cfg_ready, commit_done, hit, hit_valid
  );

  modport slave (
    input  ivar, ivar_valid, ivar_last, cfg_wr, cfg_addr, cfg_data, commit_req,
    output cfg_ready, commit_done, hit, hit_valid
  );

endinterface

// File: rtl/pb_range_checker_md_pb_dim_compare.sv
// One signed two-sided bound compare: in_o = min_i <= val_i <= max_i.
// An inverted range (min > max) never matches.
module pb_dim_compare
  import gc_pkg::*;
#(
  parameter int unsigned IVAR_W = IVAR_W_DEF
) (
  input  logic signed [IVAR_W-1:0] val_i,
  input  logic signed [IVAR_W-1:0] min_i,
  input  logic signed [IVAR_W-1:0] max_i,
  output logic                     in_o
);

  assign in_o = (val_i >= min_i) && (val_i <= max_i);

endmodule

// File: rtl/pb_range_checker_md.sv
// Pipelined multi-dimensional program-block range checker. Bounds are written
// into a shadow bank and copied to the active bank at an iteration boundary;
// hit is produced two cycles after each sample.
module pb_range_checker_md
  import gc_pkg::*;
#(
  parameter int unsigned IVAR_W  = IVAR_W_DEF,
  parameter int unsigned NUM_DIM = 3,
  parameter int unsigned NUM_PB  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  pb_range_checker_md_if.slave bus
);

  localparam int unsigned PB_W  = CLOG2(NUM_PB);
  localparam int unsigned DIM_W = CLOG2(NUM_DIM);

  logic signed [IVAR_W-1:0] sh_min_q [NUM_PB][NUM_DIM];
  logic signed [IVAR_W-1:0] sh_max_q [NUM_PB][NUM_DIM];
  logic        [NUM_PB-1:0] sh_ign_q;
  logic signed [IVAR_W-1:0] ac_min_q [NUM_PB][NUM_DIM];
  logic signed [IVAR_W-1:0] ac_max_q [NUM_PB][NUM_DIM];
  logic        [NUM_PB-1:0] ac_ign_q;

  commit_st_e state_q, state_d;
  logic       swap;
  logic       cfg_ready_c;
  logic       commit_done_q;

  cfg_field_e       fld;
  logic [DIM_W-1:0] dim_idx;
  logic [PB_W-1:0]  pb_idx;
  logic             wr_en;

  logic [NUM_PB-1:0][NUM_DIM-1:0] in_c;
  logic [NUM_PB-1:0][NUM_DIM-1:0] s1_in_q;
  logic [NUM_PB-1:0]              s1_ign_q;
  logic                           s1_valid_q;
  logic [NUM_PB-1:0]              hit_c;
  logic [NUM_PB-1:0]              hit_q;
  logic                           hit_valid_q;

  assign fld     = cfg_field_e'(bus.cfg_addr[1:0]);
  assign dim_idx = bus.cfg_addr[2 +: DIM_W];
  assign pb_idx  = bus.cfg_addr[2 + DIM_W +: PB_W];
  assign wr_en   = bus.cfg_wr && cfg_ready_c;

  // Commit FSM next state; the copy happens in the first PENDING cycle that
  // is not mid-iteration.
  always_comb begin
    state_d     = state_q;
    swap        = 1'b0;
    cfg_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready_c = 1'b1;
        if (bus.commit_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (!bus.ivar_valid || bus.ivar_last) begin
          swap    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit FSM state and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_done_q <= swap;
    end
  end

  // Shadow bank writes; out-of-range pb/dim match no loop index and are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_ign_q <= '1;
      for (int unsigned p = 0; p < NUM_PB; p++) begin
        for (int unsigned d = 0; d < NUM_DIM; d++) begin
          sh_min_q[p][d] <= '0;
          sh_max_q[p][d] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int unsigned p = 0; p < NUM_PB; p++) begin
        if (pb_idx == PB_W'(p)) begin
          if (fld == CFG_IGN) sh_ign_q[p] <= bus.cfg_data[0];
          for (int unsigned d = 0; d < NUM_DIM; d++) begin
            if (dim_idx == DIM_W'(d)) begin
              if (fld == CFG_MIN) sh_min_q[p][d] <= bus.cfg_data;
              if (fld == CFG_MAX) sh_max_q[p][d] <= bus.cfg_data;
            end
          end
        end
      end
    end
  end

  // Active bank: reset values or an atomic copy of the shadow bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ac_ign_q <= '1;
      for (int unsigned p = 0; p < NUM_PB; p++) begin
        for (int unsigned d = 0; d < NUM_DIM; d++) begin
          ac_min_q[p][d] <= '0;
          ac_max_q[p][d] <= '0;
        end
      end
    end else if (swap) begin
      ac_ign_q <= sh_ign_q;
      ac_min_q <= sh_min_q;
      ac_max_q <= sh_max_q;
    end
  end

  for (genvar p = 0; p < NUM_PB; p++) begin : g_pb
    for (genvar d = 0; d < NUM_DIM; d++) begin : g_dim
      pb_dim_compare #(.IVAR_W(IVAR_W)) u_cmp (
        .val_i (bus.ivar[d*IVAR_W +: IVAR_W]),
        .min_i (ac_min_q[p][d]),
        .max_i (ac_max_q[p][d]),
        .in_o  (in_c[p][d])
      );
    end
  end

  // S1: capture per-dim compare bits with the ignore flags of the same bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_in_q    <= '0;
      s1_ign_q   <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_in_q    <= in_c;
      s1_ign_q   <= ac_ign_q;
      s1_valid_q <= bus.ivar_valid;
    end
  end

  // Per-PB reduction of the S1 compare bits.
  always_comb begin
    hit_c = '0;
    for (int unsigned p = 0; p < NUM_PB; p++) begin
      hit_c[p] = s1_ign_q[p] | (&s1_in_q[p]);
    end
  end

  // S2: register hit, holding it across invalid cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q       <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      hit_valid_q <= s1_valid_q;
      if (s1_valid_q) hit_q <= hit_c;
    end
  end

  assign bus.cfg_ready   = cfg_ready_c;
  assign bus.commit_done = commit_done_q;
  assign bus.hit         = hit_q;
  assign bus.hit_valid   = hit_valid_q;

endmodule
